// File: rtl/random_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : random_arbiter_if
// Description : Bundle between the random_arbiter, its requesters and the
//               shared random generator.
//               slave  - arbiter side (drives o_*, receives i_*)
//               master - requester / generator side (drives i_*, receives o_*)
//               Signals:
//                 i_Req         request per requester, held until acknowledged
//                 o_Ack         one-hot, one-cycle acknowledge
//                 o_Data        last captured random word
//                 o_Rand_Enable one-cycle start pulse to the generator
//                 i_Rand_Data   generator output word
//                 i_Rand_Done   generator completion strobe
//                 o_Busy        arbiter not idle
//                 o_Timeout     sticky "generator never completed" flag
// Revision    : 1.0 - initial release
// ============================================================================
interface random_arbiter_if #(
    parameter int NUM_BITS = 4,
    parameter int NUM_REQ  = 3
);
    logic [NUM_REQ-1:0]  i_Req;
    logic [NUM_REQ-1:0]  o_Ack;
    logic [NUM_BITS-1:0] o_Data;
    logic                o_Rand_Enable;
    logic [NUM_BITS-1:0] i_Rand_Data;
    logic                i_Rand_Done;
    logic                o_Busy;
    logic                o_Timeout;

    modport slave (
        input  i_Req,
        input  i_Rand_Data,
        input  i_Rand_Done,
        output o_Ack,
        output o_Data,
        output o_Rand_Enable,
        output o_Busy,
        output o_Timeout
    );

    modport master (
        output i_Req,
        output i_Rand_Data,
        output i_Rand_Done,
        input  o_Ack,
        input  o_Data,
        input  o_Rand_Enable,
        input  o_Busy,
        input  o_Timeout
    );
endinterface
`default_nettype wire

// File: rtl/random_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : random_arbiter
// Description : Shares one random generator among NUM_REQ requesters.
//               Round-robin arbitration, one-cycle generator enable, waits
//               for the done strobe (bounded by TIMEOUT_CYCLES) and returns
//               the captured word with a one-cycle one-hot acknowledge.
// Ports       : i_Clk   - rising-edge clock
//               i_Reset - synchronous active-high reset
//               io_bus  - random_arbiter_if.slave (requests, acks, data,
//                         generator handshake, busy / timeout status)
// Revision    : 1.0 - initial release
// ============================================================================
module random_arbiter #(
    parameter int NUM_BITS       = 4,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic       i_Clk,
    input  wire logic       i_Reset,
    random_arbiter_if.slave io_bus
);

    localparam int c_GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_START   = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_DELIVER = 2'd3;

    // Last-grant pointer resets to the top requester so requester 0 wins first.
    localparam logic [c_GNT_W-1:0] c_LAST_RST = c_GNT_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    logic [1:0]          r_state;
    logic [c_GNT_W-1:0]  r_grant;
    logic [c_GNT_W-1:0]  r_last;
    logic [c_CNT_W-1:0]  r_count;
    logic [NUM_BITS-1:0] r_data;
    logic                r_timeout;

    logic [1:0]          w_state_nx;
    logic [c_GNT_W-1:0]  w_grant_nx;
    logic [c_GNT_W-1:0]  w_last_nx;
    logic [c_CNT_W-1:0]  w_count_nx;
    logic [NUM_BITS-1:0] w_data_nx;
    logic                w_timeout_nx;
    logic [c_CNT_W-1:0]  w_count_inc;

    logic                w_found;
    logic [c_GNT_W-1:0]  w_pick;

    logic [NUM_REQ-1:0]  w_ack;
    logic                w_enable;
    logic                w_busy;

    assign w_count_inc = r_count + c_CNT_W'(1);

    // Round-robin search: walk from the requester after the last grant,
    // wrapping, and take the first pending bit. The last-granted requester
    // is visited last, giving it the lowest priority.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            v_idx = (int'(r_last) + off) % NUM_REQ;
            if (!w_found && (((io_bus.i_Req >> v_idx) & c_ONE) != '0)) begin
                w_found = 1'b1;
                w_pick  = c_GNT_W'(v_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // State register (all datapath registers advance with the state)
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state   <= c_ST_IDLE;
            r_grant   <= '0;
            r_last    <= c_LAST_RST;
            r_count   <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_last    <= w_last_nx;
            r_count   <= w_count_nx;
            r_data    <= w_data_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_last_nx    = r_last;
        w_count_nx   = r_count;
        w_data_nx    = r_data;
        w_timeout_nx = r_timeout;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_grant_nx = w_pick;
                    w_state_nx = c_ST_START;
                end
            end
            c_ST_START: begin
                w_count_nx = '0;
                w_state_nx = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // Done is checked first so it wins over a coinciding timeout.
                if (io_bus.i_Rand_Done) begin
                    w_data_nx  = io_bus.i_Rand_Data;
                    w_state_nx = c_ST_DELIVER;
                end else begin
                    w_count_nx = w_count_inc;
                    if (w_count_inc == c_TIMEOUT) begin
                        w_timeout_nx = 1'b1;
                        w_last_nx    = r_grant;
                        w_state_nx   = c_ST_IDLE;
                    end
                end
            end
            c_ST_DELIVER: begin
                w_last_nx  = r_grant;
                w_state_nx = c_ST_IDLE;
            end
            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: state register only, no input feed-through
    // ------------------------------------------------------------------
    always_comb begin
        w_ack    = '0;
        w_enable = 1'b0;
        w_busy   = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_START:   w_enable = 1'b1;
            c_ST_DELIVER: w_ack    = c_ONE << r_grant;
            default:      w_ack    = '0;
        endcase
    end

    assign io_bus.o_Ack         = w_ack;
    assign io_bus.o_Rand_Enable = w_enable;
    assign io_bus.o_Busy        = w_busy;
    assign io_bus.o_Data        = r_data;
    assign io_bus.o_Timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_random_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_arbiter
// Description : Directed self-checking bench for random_arbiter
//               (NUM_BITS=4, NUM_REQ=3, TIMEOUT_CYCLES=8). Expected acks and
//               words go into a scoreboard queue when stimulus is driven and
//               are popped when the arbiter acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_arbiter;

    logic clk;
    logic rst;

    random_arbiter_if #(.NUM_BITS(4), .NUM_REQ(3)) bus ();

    random_arbiter #(
        .NUM_BITS       (4),
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ack;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   en_cnt   = 0;
    int   ack_cnt  = 0;
    int   pushed   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_Busy === 1'b1)        busy_cnt++;
        if (bus.o_Rand_Enable === 1'b1) en_cnt++;
        if (bus.o_Ack !== 3'b000)       ack_cnt++;
    endtask

    task automatic push(input logic [2:0] ack, input logic [3:0] data);
        exp_t e;
        e.ack  = ack;
        e.data = data;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ack"}, bus.o_Ack, e.ack);
            chk({tag, "_data"}, bus.o_Data, e.data);
        end
    endtask

    task automatic wait_start(input string tag, output int s);
        int n;
        n = 0;
        while (bus.o_Rand_Enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, bus.o_Rand_Enable, 1);
        s = cyc;
    endtask

    // From before START: wait for the enable pulse, present done in WAIT
    // cycle done_wait, then land in the cycle after and check the scoreboard.
    task automatic serve(input string tag, input int done_wait, input logic [3:0] word,
                         input logic [2:0] drop_mask, output int s);
        wait_start(tag, s);
        for (int w = 1; w <= done_wait; w++) begin
            tick();
            if (w == 1) bus.i_Req = bus.i_Req & ~drop_mask;
            bus.i_Rand_Done = (w == done_wait);
            bus.i_Rand_Data = (w == done_wait) ? word : ~word;
        end
        tick();
        bus.i_Rand_Done = 1'b0;
        bus.i_Rand_Data = ~word;
        sb_check(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},     bus.o_Ack, 0);
        chk({tag, "_data"},    bus.o_Data, 0);
        chk({tag, "_enable"},  bus.o_Rand_Enable, 0);
        chk({tag, "_busy"},    bus.o_Busy, 0);
        chk({tag, "_timeout"}, bus.o_Timeout, 0);
    endtask

    initial begin
        int s;
        int s_prev;
        int req_cyc;
        int ack_snap;

        rst             = 1'b1;
        bus.i_Req       = 3'b000;
        bus.i_Rand_Done = 1'b0;
        bus.i_Rand_Data = 4'h0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single request, done in the first WAIT cycle
        busy_cnt  = 0;
        bus.i_Req = 3'b001;
        req_cyc   = cyc;
        push(3'b001, 4'hA);
        serve("single", 1, 4'hA, 3'b000, s);
        chk("single_en_lat", s - req_cyc, 1);
        chk("single_ack_lat", cyc - req_cyc, 3);
        bus.i_Req = 3'b000;
        tick();
        chk("single_busy_cycles", busy_cnt, 3);
        chk("single_idle_busy", bus.o_Busy, 0);
        chk("single_data_hold", bus.o_Data, 4'hA);

        // Round-robin from reset with all requesters active
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.i_Req = 3'b111;
        push(3'b001, 4'h1);
        serve("rr0", 1, 4'h1, 3'b000, s_prev);
        bus.i_Req = bus.i_Req & ~bus.o_Ack;
        tick();
        bus.i_Req = 3'b111;
        push(3'b010, 4'h2);
        serve("rr1", 1, 4'h2, 3'b000, s);
        chk("rr1_spacing", s - s_prev, 4);
        s_prev    = s;
        bus.i_Req = bus.i_Req & ~bus.o_Ack;
        tick();
        bus.i_Req = 3'b111;
        push(3'b100, 4'h4);
        serve("rr2", 1, 4'h4, 3'b000, s);
        chk("rr2_spacing", s - s_prev, 4);
        s_prev    = s;
        bus.i_Req = bus.i_Req & ~bus.o_Ack;
        tick();
        bus.i_Req = 3'b111;
        push(3'b001, 4'h8);
        serve("rr3", 1, 4'h8, 3'b000, s);
        chk("rr3_spacing", s - s_prev, 4);
        bus.i_Req = 3'b000;
        tick();

        // Variable latency: five WAIT cycles elapse before done
        en_cnt    = 0;
        bus.i_Req = 3'b010;
        push(3'b010, 4'h5);
        serve("lat", 6, 4'h5, 3'b000, s);
        chk("lat_ack_after_start", cyc - s, 7);
        bus.i_Req = 3'b000;
        tick();
        chk("lat_one_enable", en_cnt, 1);
        // Stray done while idle must not touch o_Data
        bus.i_Rand_Done = 1'b1;
        bus.i_Rand_Data = 4'hF;
        tick();
        tick();
        bus.i_Rand_Done = 1'b0;
        tick();
        chk("stray_data", bus.o_Data, 4'h5);
        chk("stray_busy", bus.o_Busy, 0);

        // Timeout: grant goes to requester 0 (last was 1), done never comes
        ack_snap  = ack_cnt;
        bus.i_Req = 3'b011;
        wait_start("to", s);
        for (int w = 1; w <= 8; w++) begin
            tick();
            chk("to_wait_flag", bus.o_Timeout, 0);
        end
        tick();
        chk("to_flag", bus.o_Timeout, 1);
        chk("to_idle", bus.o_Busy, 0);
        chk("to_cycles", cyc - s, 9);
        chk("to_no_ack", ack_cnt, ack_snap);
        // Requester 0 lost priority, requester 1 is next
        push(3'b010, 4'h9);
        serve("to_next", 1, 4'h9, 3'b000, s);
        bus.i_Req = 3'b000;
        tick();
        chk("to_sticky", bus.o_Timeout, 1);

        // Done coinciding with the final timeout count is delivered
        rst = 1'b1;
        tick();
        chk_reset_outputs("rst2");
        rst       = 1'b0;
        bus.i_Req = 3'b001;
        push(3'b001, 4'h6);
        serve("edge", 8, 4'h6, 3'b000, s);
        chk("edge_timeout", bus.o_Timeout, 0);
        bus.i_Req = 3'b000;
        tick();
        chk("edge_timeout_after", bus.o_Timeout, 0);

        // Reset during WAIT abandons the request
        ack_snap  = ack_cnt;
        bus.i_Req = 3'b100;
        wait_start("mid", s);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        rst             = 1'b0;
        bus.i_Req       = 3'b000;
        bus.i_Rand_Done = 1'b1;
        bus.i_Rand_Data = 4'h7;
        tick();
        bus.i_Rand_Done = 1'b0;
        tick();
        chk("mid_late_done_data", bus.o_Data, 0);
        chk("mid_no_ack", ack_cnt, ack_snap);
        bus.i_Req = 3'b111;
        push(3'b001, 4'h3);
        serve("mid_next", 1, 4'h3, 3'b000, s);
        bus.i_Req = 3'b000;
        tick();

        // Request withdrawn during WAIT still gets its ack
        bus.i_Req = 3'b100;
        push(3'b100, 4'hC);
        serve("wd", 3, 4'hC, 3'b100, s);
        tick();
        chk("wd_idle_busy", bus.o_Busy, 0);
        chk("wd_idle_ack", bus.o_Ack, 0);
        tick();
        tick();

        chk("total_acks", ack_cnt, pushed);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
